// File: rtl/jtframe_dpram_clr.sv
// Dual-port RAM (port 0 read/write with lane enables, port 1 read-only) with a
// clear sequencer that sweeps CLRVAL through every word after reset or on clr.
module jtframe_dpram_clr #(
    parameter int unsigned   DW      = 8,
    parameter int unsigned   AW      = 10,
    parameter int unsigned   LW      = 8,
    parameter int unsigned   RDLY    = 1,
    parameter logic [DW-1:0] CLRVAL  = '0,
    parameter bit            CLR_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             busy,
    input  logic             cen0,
    input  logic [AW-1:0]    addr0,
    input  logic [DW-1:0]    data0,
    input  logic [DW/LW-1:0] we0,
    output logic [DW-1:0]    q0,
    input  logic             cen1,
    input  logic [AW-1:0]    addr1,
    output logic [DW-1:0]    q1
);
    localparam int unsigned NL    = DW / LW;
    localparam int unsigned DEPTH = 1 << AW;

    if (RDLY != 1 && RDLY != 2) begin : g_bad_rdly
        $error("jtframe_dpram_clr: RDLY must be 1 or 2");
    end
    if (DW % LW != 0) begin : g_bad_lanes
        $error("jtframe_dpram_clr: DW must be a multiple of LW");
    end

    typedef enum logic { IDLE, CLEAR } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s1_0, s1_1;

`ifdef SIMULATION
    initial begin
        if (!CLR_RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] = CLRVAL;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLR_RST) state <= CLEAR;
            else         state <= IDLE;
            cnt  <= '0;
            busy <= CLR_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The sweep owns the write port; port 0 writes only land outside it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= CLRVAL;
        end else if (cen0) begin
            for (int unsigned i = 0; i < NL; i++) begin
                if (we0[i]) mem[addr0][i*LW +: LW] <= data0[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_0 <= '0;
            s1_1 <= '0;
        end else if (busy) begin
            s1_0 <= '0;
            s1_1 <= '0;
        end else begin
            if (cen0) s1_0 <= mem[addr0];
            if (cen1) s1_1 <= mem[addr1];
        end
    end

    if (RDLY == 2) begin : g_rdly2
        // Second stage also flushes while busy so the output reads zero throughout a sweep.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q0 <= '0;
                q1 <= '0;
            end else begin
                if (cen0 || busy) q0 <= s1_0;
                if (cen1 || busy) q1 <= s1_1;
            end
        end
    end else begin : g_rdly1
        assign q0 = s1_0;
        assign q1 = s1_1;
    end

endmodule
